// File: rtl/msd_dram_pkg.sv
// msd_dram_pkg: shared types and field widths for the DDR5 command responder.
//   cmd_e         - command opcodes carried on cmd_op
//   err_e         - protocol error codes reported on err_code
//   seq_state_e   - two-part command sequencer states
//   bank_entry_t  - per-bank open/row/tRCD state
package msd_dram_pkg;

  localparam int unsigned CH_W       = 1;
  localparam int unsigned BG_W       = 3;
  localparam int unsigned BA_W       = 2;
  localparam int unsigned ROW_W      = 16;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned IDX_W      = CH_W + BG_W + BA_W;
  localparam int unsigned NUM_BANKS  = 1 << IDX_W;
  localparam int unsigned TAG_W      = IDX_W + COL_W;
  localparam int unsigned RDATA_W    = IDX_W + ROW_W + COL_W;
  localparam int unsigned TRCD_CNT_W = 8;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ACT0 = 4'd1,
    ACT1 = 4'd2,
    RD0  = 4'd3,
    RD1  = 4'd4,
    WR0  = 4'd5,
    WR1  = 4'd6,
    PRE  = 4'd7,
    REF  = 4'd8
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_SEQ      = 3'd1,
    ERR_ACT_OPEN = 3'd2,
    ERR_CLOSED   = 3'd3,
    ERR_TRCD     = 3'd4,
    ERR_REF_OPEN = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACT1,
    WAIT_RD1,
    WAIT_WR1
  } seq_state_e;

  typedef struct packed {
    logic                  open;
    logic [ROW_W-1:0]      row;
    logic [TRCD_CNT_W-1:0] trcd_cnt;
  } bank_entry_t;

endpackage

// File: rtl/msd_bank_table.sv
// msd_bank_table: 64-entry open-row table indexed {ch,bg,ba}.
//   clk_i, rst_ni  - clock, asynchronous active-low reset (clears all entries)
//   rd_idx_i       - lookup index; rd_entry_o is the current (pre-edge) entry
//   upd_en_i       - write upd_entry_i into entry upd_idx_i on the next edge
//   any_open_o     - high when at least one bank is open
// Every non-updated entry's trcd_cnt counts down to zero each cycle.
module msd_bank_table
  import msd_dram_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bank_entry_t      rd_entry_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  bank_entry_t      upd_entry_i,
  output logic             any_open_o
);

  bank_entry_t tbl_q [NUM_BANKS];
  bank_entry_t tbl_d [NUM_BANKS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      tbl_d[i] = tbl_q[i];
      if (tbl_q[i].trcd_cnt != '0) tbl_d[i].trcd_cnt = tbl_q[i].trcd_cnt - 1'b1;
    end
    if (upd_en_i) tbl_d[upd_idx_i] = upd_entry_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) tbl_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  always_comb begin
    rd_entry_o = tbl_q[rd_idx_i];
  end

  always_comb begin
    any_open_o = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) any_open_o = any_open_o | tbl_q[i].open;
  end

endmodule

// File: rtl/msd_dram_cmd_responder.sv
// msd_dram_cmd_responder: DRAM-side responder for the DDR5 command stream.
//   clk, rst_n            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake; ready drops for TRFC cycles after REF
//   cmd_op/ch/bg/ba/row/col - command fields (cmd_op is msd_dram_pkg::cmd_e)
//   rsp_valid/tag/data    - read response, CL cycles after each completed read
//   err_valid/err_code    - one-cycle registered protocol error report
module msd_dram_cmd_responder
  import msd_dram_pkg::*;
#(
  parameter int unsigned CL     = 40,
  parameter int unsigned TRCD   = 8,
  parameter int unsigned TRFC   = 16,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_ch,
  input  logic [2:0]        cmd_bg,
  input  logic [1:0]        cmd_ba,
  input  logic [15:0]       cmd_row,
  input  logic [5:0]        cmd_col,
  output logic              rsp_valid,
  output logic [11:0]       rsp_tag,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam int unsigned REF_W = $clog2(TRFC + 1);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  cmd_e             op;
  logic             acc;
  logic [IDX_W-1:0] cmd_idx;
  bank_entry_t      rd_entry;
  logic             any_open;
  logic             trcd_ok;

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [ROW_W-1:0] pend_row_q, pend_row_d;
  logic [COL_W-1:0] pend_col_q, pend_col_d;
  logic             err_vld_q, err_vld_d;
  err_e             err_code_q, err_code_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             cmd_ready_q;

  logic             upd_en;
  bank_entry_t      upd_entry;
  logic             push;
  logic             ref_start;
  rsp_t             dl_in;
  rsp_t             dl_q [CL];

  assign op      = cmd_e'(cmd_op);
  assign acc     = cmd_valid && cmd_ready_q;
  assign cmd_idx = {cmd_ch, cmd_bg, cmd_ba};
  // The counter ticks on the same edge that accepts RD0/WR0, so a value of 1
  // here means tRCD has fully elapsed at that edge.
  assign trcd_ok = (rd_entry.trcd_cnt <= TRCD_CNT_W'(1));

  msd_bank_table u_bank_table (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_idx_i    (cmd_idx),
    .rd_entry_o  (rd_entry),
    .upd_en_i    (upd_en),
    .upd_idx_i   (cmd_idx),
    .upd_entry_i (upd_entry),
    .any_open_o  (any_open)
  );

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_row_d = pend_row_q;
    pend_col_d = pend_col_q;
    err_vld_d  = 1'b0;
    err_code_d = ERR_NONE;
    upd_en     = 1'b0;
    upd_entry  = '0;
    push       = 1'b0;
    ref_start  = 1'b0;
    if (acc && op != NOP) begin
      case (state_q)
        IDLE: begin
          case (op)
            ACT0: begin
              state_d    = WAIT_ACT1;
              pend_idx_d = cmd_idx;
              pend_row_d = cmd_row;
            end
            RD0, WR0: begin
              if (!rd_entry.open) begin
                err_vld_d  = 1'b1;
                err_code_d = ERR_CLOSED;
              end else if (!trcd_ok) begin
                err_vld_d  = 1'b1;
                err_code_d = ERR_TRCD;
              end else begin
                state_d    = (op == RD0) ? WAIT_RD1 : WAIT_WR1;
                pend_idx_d = cmd_idx;
                pend_col_d = cmd_col;
              end
            end
            ACT1, RD1, WR1: begin
              err_vld_d  = 1'b1;
              err_code_d = ERR_SEQ;
            end
            PRE: begin
              // Writing an all-zero entry closes the bank and clears trcd_cnt.
              upd_en = 1'b1;
            end
            REF: begin
              if (any_open) begin
                err_vld_d  = 1'b1;
                err_code_d = ERR_REF_OPEN;
              end else begin
                ref_start = 1'b1;
              end
            end
            default: ;
          endcase
        end
        WAIT_ACT1: begin
          state_d = IDLE;
          if (op == ACT1 && cmd_idx == pend_idx_q && cmd_row == pend_row_q) begin
            if (rd_entry.open) begin
              err_vld_d  = 1'b1;
              err_code_d = ERR_ACT_OPEN;
            end else begin
              upd_en             = 1'b1;
              upd_entry.open     = 1'b1;
              upd_entry.row      = cmd_row;
              upd_entry.trcd_cnt = TRCD_CNT_W'(TRCD);
            end
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_SEQ;
          end
        end
        WAIT_RD1: begin
          state_d = IDLE;
          if (op == RD1 && cmd_idx == pend_idx_q && cmd_col == pend_col_q) begin
            push = 1'b1;
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_SEQ;
          end
        end
        WAIT_WR1: begin
          state_d = IDLE;
          if (!(op == WR1 && cmd_idx == pend_idx_q && cmd_col == pend_col_q)) begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_SEQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (ref_start) begin
      ref_cnt_d = REF_W'(TRFC);
    end else if (ref_cnt_q != '0) begin
      ref_cnt_d = ref_cnt_q - 1'b1;
    end else begin
      ref_cnt_d = '0;
    end
  end

  always_comb begin
    dl_in = '0;
    if (push) begin
      dl_in.vld  = 1'b1;
      dl_in.tag  = {cmd_idx, cmd_col};
      dl_in.data = DATA_W'({cmd_idx, rd_entry.row, cmd_col});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_idx_q  <= '0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
      err_vld_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      ref_cnt_q   <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_idx_q  <= pend_idx_d;
      pend_row_q  <= pend_row_d;
      pend_col_q  <= pend_col_d;
      err_vld_q   <= err_vld_d;
      err_code_q  <= err_code_d;
      ref_cnt_q   <= ref_cnt_d;
      cmd_ready_q <= (ref_cnt_d == '0);
    end
  end

  // CL-stage shift register: entry loaded at edge n reaches the last stage
  // after edge n+CL-1, i.e. is visible during cycle n+CL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CL; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= dl_in;
      for (int unsigned i = 1; i < CL; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign err_valid = err_vld_q;
  assign err_code  = err_code_q;
  assign rsp_valid = dl_q[CL-1].vld;
  assign rsp_tag   = dl_q[CL-1].tag;
  assign rsp_data  = dl_q[CL-1].data;

endmodule

// File: tb/tb_msd_dram_cmd_responder.sv
module tb_msd_dram_cmd_responder;
  import msd_dram_pkg::*;

  localparam int unsigned CL     = 40;
  localparam int unsigned TRCD   = 8;
  localparam int unsigned TRFC   = 16;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_op = '0;
  logic              cmd_ch = 1'b0;
  logic [2:0]        cmd_bg = '0;
  logic [1:0]        cmd_ba = '0;
  logic [15:0]       cmd_row = '0;
  logic [5:0]        cmd_col = '0;
  logic              rsp_valid;
  logic [11:0]       rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              err_valid;
  logic [2:0]        err_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int                due;
    logic [11:0]       tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Results of the most recent issue() call.
  logic       ev;
  logic [2:0] ec;
  int         acc;

  msd_dram_cmd_responder #(
    .CL     (CL),
    .TRCD   (TRCD),
    .TRFC   (TRFC),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_bg    (cmd_bg),
    .cmd_ba    (cmd_ba),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard: compares every rsp_valid against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL rsp_missing: no response by cycle %0d, required at cycle %0d tag=%h", cyc, sb[0].due, sb[0].tag);
        void'(sb.pop_front());
      end
      if (rsp_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: rsp_valid=1 tag=%h at cycle %0d, required no response", rsp_tag, cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || rsp_tag !== e.tag || rsp_data !== e.data) begin
            bad++;
            $display("FAIL rsp_match: cycle=%0d tag=%h data=%h, required cycle=%0d tag=%h data=%h",
                     cyc, rsp_tag, rsp_data, e.due, e.tag, e.data);
          end
        end
      end
    end
  end

  // Drives one command from a falling edge; returns at the next falling edge
  // with the registered error outputs for that command in ev/ec.
  task automatic issue(input cmd_e op, input logic ch, input logic [2:0] bg, input logic [1:0] ba,
                       input logic [15:0] row, input logic [5:0] col);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, required 1", n);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_bg    = bg;
    cmd_ba    = ba;
    cmd_row   = row;
    cmd_col   = col;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    ev  = err_valid;
    ec  = err_code;
    acc = cyc;
  endtask

  task automatic expect_read(input logic ch, input logic [2:0] bg, input logic [1:0] ba,
                             input logic [15:0] row, input logic [5:0] col);
    exp_t x;
    x.due  = acc + int'(CL) - 1;
    x.tag  = {ch, bg, ba, col};
    x.data = DATA_W'({ch, bg, ba, row, col});
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < int'(CL) + 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    total++;
    if ({rsp_valid, err_valid, err_code, rsp_tag} !== '0 || rsp_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rsp_valid=%b tag=%h data=%h err_valid=%b err_code=%0d, required all 0",
               rsp_valid, rsp_tag, rsp_data, err_valid, err_code);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    issue(ACT0, 1'b0, 3'd2, 2'd1, 16'h1234, 6'd0);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL read_act0: err_valid=%b code=%0d, required 0", ev, ec); end
    issue(ACT1, 1'b0, 3'd2, 2'd1, 16'h1234, 6'd0);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL read_act1: err_valid=%b code=%0d, required 0", ev, ec); end
    repeat (TRCD - 1) @(negedge clk);
    issue(RD0, 1'b0, 3'd2, 2'd1, 16'h0, 6'd5);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL read_rd0_at_trcd: err_valid=%b code=%0d, required 0", ev, ec); end
    issue(RD1, 1'b0, 3'd2, 2'd1, 16'h0, 6'd5);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL read_rd1: err_valid=%b code=%0d, required 0", ev, ec); end
    expect_read(1'b0, 3'd2, 2'd1, 16'h1234, 6'd5);
    wait_drain();
    issue(PRE, 1'b0, 3'd2, 2'd1, 16'h0, 6'd0);
  endtask

  task automatic test_trcd();
    issue(ACT0, 1'b0, 3'd3, 2'd0, 16'h0055, 6'd0);
    issue(ACT1, 1'b0, 3'd3, 2'd0, 16'h0055, 6'd0);
    repeat (TRCD - 2) @(negedge clk);
    issue(RD0, 1'b0, 3'd3, 2'd0, 16'h0, 6'd7);
    total++;
    if (ev !== 1'b1 || ec !== ERR_TRCD) begin
      bad++;
      $display("FAIL trcd_early: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_TRCD);
    end
    issue(RD1, 1'b0, 3'd3, 2'd0, 16'h0, 6'd7);
    total++;
    if (ev !== 1'b1 || ec !== ERR_SEQ) begin
      bad++;
      $display("FAIL trcd_orphan_rd1: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_SEQ);
    end
    repeat (CL + 5) @(negedge clk);
    issue(PRE, 1'b0, 3'd3, 2'd0, 16'h0, 6'd0);
  endtask

  task automatic test_seq();
    issue(ACT0, 1'b1, 3'd5, 2'd2, 16'h0AAA, 6'd0);
    issue(RD1, 1'b1, 3'd5, 2'd2, 16'h0, 6'd3);
    total++;
    if (ev !== 1'b1 || ec !== ERR_SEQ) begin
      bad++;
      $display("FAIL seq_act0_rd1: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_SEQ);
    end
    issue(ACT0, 1'b1, 3'd5, 2'd2, 16'h0AAA, 6'd0);
    issue(ACT1, 1'b1, 3'd5, 2'd2, 16'h0AAA, 6'd0);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL seq_reopen: err_valid=%b code=%0d, required 0", ev, ec); end
    issue(WR1, 1'b1, 3'd5, 2'd2, 16'h0, 6'd1);
    total++;
    if (ev !== 1'b1 || ec !== ERR_SEQ) begin
      bad++;
      $display("FAIL seq_lone_wr1: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_SEQ);
    end
    repeat (TRCD) @(negedge clk);
    issue(WR0, 1'b1, 3'd5, 2'd2, 16'h0, 6'd1);
    issue(WR1, 1'b1, 3'd5, 2'd2, 16'h0, 6'd2);
    total++;
    if (ev !== 1'b1 || ec !== ERR_SEQ) begin
      bad++;
      $display("FAIL seq_col_mismatch: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_SEQ);
    end
    issue(WR0, 1'b1, 3'd5, 2'd2, 16'h0, 6'd1);
    issue(WR1, 1'b1, 3'd5, 2'd2, 16'h0, 6'd1);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL seq_write: err_valid=%b code=%0d, required 0", ev, ec); end
    issue(PRE, 1'b1, 3'd5, 2'd2, 16'h0, 6'd0);
  endtask

  task automatic test_act_open_ref();
    int mism = 0;
    issue(ACT0, 1'b1, 3'd0, 2'd0, 16'h0001, 6'd0);
    issue(ACT1, 1'b1, 3'd0, 2'd0, 16'h0001, 6'd0);
    issue(ACT0, 1'b1, 3'd0, 2'd0, 16'h0002, 6'd0);
    issue(ACT1, 1'b1, 3'd0, 2'd0, 16'h0002, 6'd0);
    total++;
    if (ev !== 1'b1 || ec !== ERR_ACT_OPEN) begin
      bad++;
      $display("FAIL act_open: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_ACT_OPEN);
    end
    repeat (TRCD) @(negedge clk);
    issue(RD0, 1'b1, 3'd0, 2'd0, 16'h0, 6'd9);
    issue(RD1, 1'b1, 3'd0, 2'd0, 16'h0, 6'd9);
    expect_read(1'b1, 3'd0, 2'd0, 16'h0001, 6'd9);
    issue(PRE, 1'b1, 3'd0, 2'd0, 16'h0, 6'd0);
    issue(REF, 1'b0, 3'd0, 2'd0, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL ref_legal: err_valid=%b code=%0d, required 0", ev, ec); end
    for (int i = 0; i <= int'(TRFC); i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_ready !== (i >= int'(TRFC))) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL ref_window: %0d of %0d cycles had wrong cmd_ready, required low exactly %0d cycles", mism, TRFC + 1, TRFC);
    end
    wait_drain();
  endtask

  task automatic test_ref_open();
    issue(ACT0, 1'b0, 3'd0, 2'd3, 16'h0007, 6'd0);
    issue(ACT1, 1'b0, 3'd0, 2'd3, 16'h0007, 6'd0);
    issue(REF, 1'b0, 3'd0, 2'd0, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b1 || ec !== ERR_REF_OPEN) begin
      bad++;
      $display("FAIL ref_open: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_REF_OPEN);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ref_open_ready: cmd_ready=%b, required 1", cmd_ready); end
    issue(ACT0, 1'b0, 3'd7, 2'd2, 16'h0003, 6'd0);
    issue(ACT1, 1'b0, 3'd7, 2'd2, 16'h0003, 6'd0);
    issue(PRE, 1'b0, 3'd7, 2'd2, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b0) begin bad++; $display("FAIL pre_after_act1: err_valid=%b code=%0d, required 0", ev, ec); end
    issue(PRE, 1'b0, 3'd0, 2'd3, 16'h0, 6'd0);
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int b = 0; b < 4; b++) begin
      issue(ACT0, 1'b0, 3'd1, 2'(b), 16'h0100 + 16'(b), 6'd0);
      if (ev) errs++;
      issue(ACT1, 1'b0, 3'd1, 2'(b), 16'h0100 + 16'(b), 6'd0);
      if (ev) errs++;
    end
    repeat (TRCD) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      issue(RD0, 1'b0, 3'd1, 2'(b), 16'h0, 6'(10 + b));
      if (ev) errs++;
      issue(RD1, 1'b0, 3'd1, 2'(b), 16'h0, 6'(10 + b));
      if (ev) errs++;
      expect_read(1'b0, 3'd1, 2'(b), 16'h0100 + 16'(b), 6'(10 + b));
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL b2b_errors: %0d error pulses, required 0", errs); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 4; b++) begin
      issue(RD0, 1'b0, 3'd1, 2'(b), 16'h0, 6'(20 + b));
      issue(RD1, 1'b0, 3'd1, 2'(b), 16'h0, 6'(20 + b));
      expect_read(1'b0, 3'd1, 2'(b), 16'h0100 + 16'(b), 6'(20 + b));
    end
    issue(RD1, 1'b0, 3'd1, 2'd0, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b1 || ec !== ERR_SEQ) begin
      bad++;
      $display("FAIL mid_pre_err: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_SEQ);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, err_valid, err_code, rsp_tag} !== '0 || rsp_data !== '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_outputs: rsp_valid=%b err_valid=%b err_code=%0d ready=%b, required 0/0/0/1",
               rsp_valid, err_valid, err_code, cmd_ready);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CL + 10) @(negedge clk);
    issue(RD0, 1'b0, 3'd1, 2'd0, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b1 || ec !== ERR_CLOSED) begin
      bad++;
      $display("FAIL mid_bank_closed: err_valid=%b code=%0d, required 1/%0d", ev, ec, ERR_CLOSED);
    end
    issue(REF, 1'b0, 3'd0, 2'd0, 16'h0, 6'd0);
    total++;
    if (ev !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_ref_after_reset: err_valid=%b ready=%b, required 0/0", ev, cmd_ready);
    end
    repeat (TRFC + 2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_trcd();
    test_seq();
    test_act_open_ref();
    test_ref_open();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
